// File: rtl/tuner_phy_ctrl_arb_mc_if.sv
// Bus bundle between tuner_phy_ctrl_arb_mc and its surroundings.
//
// Channel side : i_ch_req, i_ch_code  -> arbiter
//                o_ch_grant, o_ch_done, o_ch_pwr <- arbiter
// PHY side     : o_tuner_code, o_tuner_valid, o_pwr_req <- arbiter
//                i_pwr_valid, i_pwr -> arbiter
// Status       : o_state, o_err <- arbiter
//
// modport master : the arbiter's view (drives the o_* signals)
// modport slave  : the environment's view (drives the i_* signals)
interface tuner_phy_ctrl_arb_mc_if #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CODE_WIDTH = 8,
  parameter int unsigned PWR_WIDTH  = 8
);
  logic [NUM_CH-1:0]            i_ch_req;
  logic [NUM_CH*CODE_WIDTH-1:0] i_ch_code;
  logic [NUM_CH-1:0]            o_ch_grant;
  logic [NUM_CH-1:0]            o_ch_done;
  logic [PWR_WIDTH-1:0]         o_ch_pwr;
  logic [CODE_WIDTH-1:0]        o_tuner_code;
  logic                         o_tuner_valid;
  logic                         o_pwr_req;
  logic                         i_pwr_valid;
  logic [PWR_WIDTH-1:0]         i_pwr;
  logic [1:0]                   o_state;
  logic                         o_err;

  modport master (
    input  i_ch_req, i_ch_code, i_pwr_valid, i_pwr,
    output o_ch_grant, o_ch_done, o_ch_pwr, o_tuner_code, o_tuner_valid,
    output o_pwr_req, o_state, o_err
  );

  modport slave (
    output i_ch_req, i_ch_code, i_pwr_valid, i_pwr,
    input  o_ch_grant, o_ch_done, o_ch_pwr, o_tuner_code, o_tuner_valid,
    input  o_pwr_req, o_state, o_err
  );
endinterface

// File: rtl/tuner_phy_ctrl_arb_mc.sv
// Multi-channel arbiter time-sharing one tuner DAC and one power detector among
// NUM_CH controller channels (channel 0 = search, channel 1 = lock).
// Each granted transaction runs INIT -> TUNE -> SYNC -> COMMIT.
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : tuner_phy_ctrl_arb_mc_if.master (channel requests/codes, grants,
//           done pulses, power result, DAC code/strobe, detector trigger/result,
//           phase and timeout error)
//
// Optional feature: define TUNER_ARB_TIMEOUT_EN to bound the SYNC wait to
// TIMEOUT_CYCLES cycles; on expiry o_err pulses and the transaction is dropped.
// Without it SYNC waits indefinitely and o_err is tied low.
//
// All outputs are registered.
module tuner_phy_ctrl_arb_mc #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned CODE_WIDTH     = 8,
  parameter int unsigned PWR_WIDTH      = 8,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  tuner_phy_ctrl_arb_mc_if.master bus
);

  localparam int unsigned PtrW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    StInit   = 2'd0,
    StTune   = 2'd1,
    StSync   = 2'd2,
    StCommit = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [PtrW-1:0]       ptr_q, ptr_d;
  logic [PtrW-1:0]       gidx_q, gidx_d;
  logic [NUM_CH-1:0]     grant_q, grant_d;
  logic [NUM_CH-1:0]     done_q, done_d;
  logic [PWR_WIDTH-1:0]  pwr_q, pwr_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic                  tvalid_q, tvalid_d;
  logic                  preq_q, preq_d;
  logic [SetW-1:0]       settle_q, settle_d;
  logic                  err_q, err_d;

`ifdef TUNER_ARB_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TmoW-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Round-robin search: first asserted request at or after ptr_q, with wrap.
  logic            req_any;
  logic [PtrW-1:0] win_idx;
  int unsigned     cand;
  logic [PtrW-1:0] cand_idx;

  always_comb begin
    req_any  = 1'b0;
    win_idx  = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      cand_idx = PtrW'(cand);
      if (!req_any && bus.i_ch_req[cand_idx]) begin
        req_any = 1'b1;
        win_idx = cand_idx;
      end
    end
  end

  // Pointer moves just past the channel that held the grant.
  logic [PtrW-1:0] ptr_next;
  assign ptr_next = (gidx_q == PtrW'(NUM_CH - 1)) ? '0 : gidx_q + PtrW'(1);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    grant_d  = grant_q;
    done_d   = '0;
    pwr_d    = pwr_q;
    code_d   = code_q;
    tvalid_d = 1'b0;
    preq_d   = 1'b0;
    settle_d = settle_q;
    err_d    = 1'b0;
`ifdef TUNER_ARB_TIMEOUT_EN
    tmo_d    = tmo_q;
`endif

    unique case (state_q)
      StInit: begin
        if (req_any) begin
          gidx_d           = win_idx;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          code_d           = bus.i_ch_code[win_idx*CODE_WIDTH +: CODE_WIDTH];
          tvalid_d         = 1'b1;
          settle_d         = '0;
          state_d          = StTune;
        end
      end

      StTune: begin
        if (settle_q == SetW'(SETTLE_CYCLES - 1)) begin
          preq_d  = 1'b1;
          state_d = StSync;
`ifdef TUNER_ARB_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end else begin
          settle_d = settle_q + SetW'(1);
        end
      end

      StSync: begin
        // A strobe coincident with o_pwr_req is accepted as well.
        if (bus.i_pwr_valid) begin
          pwr_d   = bus.i_pwr;
          done_d  = grant_q;
          state_d = StCommit;
        end
`ifdef TUNER_ARB_TIMEOUT_EN
        else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          // Abandon the transaction: no done pulse, power result untouched.
          err_d   = 1'b1;
          grant_d = '0;
          ptr_d   = ptr_next;
          state_d = StInit;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
`endif
      end

      StCommit: begin
        grant_d = '0;
        ptr_d   = ptr_next;
        state_d = StInit;
      end

      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StInit;
      ptr_q    <= '0;
      gidx_q   <= '0;
      grant_q  <= '0;
      done_q   <= '0;
      pwr_q    <= '0;
      code_q   <= '0;
      tvalid_q <= 1'b0;
      preq_q   <= 1'b0;
      settle_q <= '0;
      err_q    <= 1'b0;
`ifdef TUNER_ARB_TIMEOUT_EN
      tmo_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      pwr_q    <= pwr_d;
      code_q   <= code_d;
      tvalid_q <= tvalid_d;
      preq_q   <= preq_d;
      settle_q <= settle_d;
      err_q    <= err_d;
`ifdef TUNER_ARB_TIMEOUT_EN
      tmo_q    <= tmo_d;
`endif
    end
  end

  assign bus.o_ch_grant    = grant_q;
  assign bus.o_ch_done     = done_q;
  assign bus.o_ch_pwr      = pwr_q;
  assign bus.o_tuner_code  = code_q;
  assign bus.o_tuner_valid = tvalid_q;
  assign bus.o_pwr_req     = preq_q;
  assign bus.o_state       = state_q;
  assign bus.o_err         = err_q;

endmodule
